wb_arbiter: RTL

Parametrised writeback arbiter between the execution units (memory, ALU/misc, multiplier, …) and the register file write port. Each source channel has its own valid/ready handshake and a small FIFO, so a unit that loses arbitration is held back instead of having its result dropped. One result per cycle is selected by fixed priority, or by round-robin when enabled, and driven to the register file from output registers. Writes to register 0 and results with the write flag clear are discarded at the input.

---
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-channel FIFOs feeding one registered register-file write port.
// Fixed priority by default; define WB_ARB_RR_EN for round-robin arbitration.
module wb_arbiter #(
   parameter int NUM_SRC = 3,
   parameter int DEPTH   = 4,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_SRC-1:0]        src_valid,
   output logic [NUM_SRC-1:0]        src_ready,
   input  logic [NUM_SRC-1:0]        src_writereg,
   input  logic [NUM_SRC*ADDR_W-1:0] src_regdest,
   input  logic [NUM_SRC*DATA_W-1:0] src_wbvalue,
   output logic                      wb_reg_en,
   output logic [ADDR_W-1:0]         wb_reg_addr,
   output logic [DATA_W-1:0]         wb_reg_data,
   output logic                      wb_busy
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [ADDR_W-1:0]  mem_addr_q [NUM_SRC][DEPTH];
   logic [DATA_W-1:0]  mem_data_q [NUM_SRC][DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q [NUM_SRC];
   logic [PTR_W-1:0]   wr_ptr_d [NUM_SRC];
   logic [PTR_W-1:0]   rd_ptr_q [NUM_SRC];
   logic [PTR_W-1:0]   rd_ptr_d [NUM_SRC];
   logic [CNT_W-1:0]   cnt_q [NUM_SRC];
   logic [CNT_W-1:0]   cnt_d [NUM_SRC];
   logic [NUM_SRC-1:0] nonempty;
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] gnt;
   logic               wb_reg_en_q, wb_reg_en_d;
   logic [ADDR_W-1:0]  wb_reg_addr_q, wb_reg_addr_d;
   logic [DATA_W-1:0]  wb_reg_data_q, wb_reg_data_d;

   // Handshake: channel i transfers on an edge where src_valid[i] & src_ready[i];
   // ready comes from the registered count only, so a same-cycle pop does not free a slot.
   // Filtered results (writereg clear or regdest zero) complete the handshake but are not stored.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         src_ready[i] = (cnt_q[i] < CNT_W'(DEPTH));
         nonempty[i]  = (cnt_q[i] != '0);
         push[i]      = src_valid[i] & (cnt_q[i] < CNT_W'(DEPTH)) & src_writereg[i]
                        & (src_regdest[i*ADDR_W +: ADDR_W] != '0);
      end
   end

`ifdef WB_ARB_RR_EN
   logic [SEL_W-1:0] last_q, last_d;

   always_comb begin
      int   c;
      logic found;
      gnt    = '0;
      last_d = last_q;
      found  = 1'b0;
      c      = 0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         c = int'(last_q) + k;
         if (c >= NUM_SRC) c = c - NUM_SRC;
         if (!found && nonempty[c]) begin
            found  = 1'b1;
            gnt[c] = 1'b1;
            last_d = SEL_W'(c);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= SEL_W'(NUM_SRC - 1);
      else        last_q <= last_d;
   end
`else
   always_comb begin
      logic found;
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!found && nonempty[i]) begin
            found  = 1'b1;
            gnt[i] = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      wb_reg_en_d   = 1'b0;
      wb_reg_addr_d = '0;
      wb_reg_data_d = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(gnt[i]);
         cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(gnt[i]);
         if (gnt[i]) begin
            wb_reg_en_d   = 1'b1;
            wb_reg_addr_d = mem_addr_q[i][rd_ptr_q[i]];
            wb_reg_data_d = mem_data_q[i][rd_ptr_q[i]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
         wb_reg_en_q   <= 1'b0;
         wb_reg_addr_q <= '0;
         wb_reg_data_q <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
         wb_reg_en_q   <= wb_reg_en_d;
         wb_reg_addr_q <= wb_reg_addr_d;
         wb_reg_data_q <= wb_reg_data_d;
      end
   end

   // Entry storage carries no reset: validity is tracked entirely by the pointers and counts.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (push[i]) begin
            mem_addr_q[i][wr_ptr_q[i]] <= src_regdest[i*ADDR_W +: ADDR_W];
            mem_data_q[i][wr_ptr_q[i]] <= src_wbvalue[i*DATA_W +: DATA_W];
         end
      end
   end

   assign wb_reg_en   = wb_reg_en_q;
   assign wb_reg_addr = wb_reg_addr_q;
   assign wb_reg_data = wb_reg_data_q;
   assign wb_busy     = (|nonempty) | wb_reg_en_q;

endmodule
